// File: rtl/fir4_chan_sched.sv
// rtl/fir4_chan_sched.sv - shared 4-tap sum datapath, round-robin (FIR_SCHED_RR_EN) or fixed-priority channel grant
module fir4_chan_sched #(
    parameter int w   = 4,
    parameter int NCH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NCH-1:0]          in_valid,
    input  logic [NCH*w-1:0]        in_data,
    output logic [NCH-1:0]          in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(NCH)-1:0]  out_ch,
    output logic [w+1:0]            out_sum
);

    localparam int CW = $clog2(NCH);

    logic [w-1:0]   samples [NCH];
    logic [w-1:0]   hist    [NCH][4];
    logic [CW-1:0]  ptr;
    logic [CW-1:0]  gidx;
    logic [CW-1:0]  k;
    logic [NCH-1:0] pick;
    logic           hit;
    logic           stall;
    logic           xfer;
    logic [w-1:0]   sel_data;
    logic [w+1:0]   sum_next;

    // (base + off) mod NCH; both operands are below NCH so one subtraction suffices
    function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base, input int off);
        logic [CW:0] s;
        s = {1'b0, base} + (CW+1)'(off);
        if (s >= (CW+1)'(NCH)) begin
            s = s - (CW+1)'(NCH);
        end
        return s[CW-1:0];
    endfunction

    // Unpack the flat sample bus into one lane per channel
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            samples[c] = in_data[c*w +: w];
        end
    end

    // First valid channel searching upward from the pointer, wrapping at NCH
    always_comb begin
        pick = '0;
        gidx = '0;
        hit  = 1'b0;
        k    = '0;
        for (int i = 0; i < NCH; i++) begin
            k = wrap_idx(ptr, i);
            if (!hit && in_valid[k]) begin
                hit     = 1'b1;
                gidx    = k;
                pick[k] = 1'b1;
            end
        end
    end

    // A held result blocks every grant; otherwise the search result is the grant
    assign stall    = out_valid & ~out_ready;
    assign in_ready = stall ? '0 : pick;
    assign xfer     = hit & ~stall;

    assign sel_data = samples[gidx];
    assign sum_next = (w+2)'(sel_data)
                    + (w+2)'(hist[gidx][0])
                    + (w+2)'(hist[gidx][1])
                    + (w+2)'(hist[gidx][2]);

`ifdef FIR_SCHED_RR_EN
    // Pointer advances past the served channel, only on a transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= wrap_idx(gidx, 1);
        end
    end
`else
    // Fixed priority: search always starts at channel 0
    assign ptr = '0;
`endif

    // Output register: load on transfer, drop valid when popped with nothing new
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_sum   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_ch    <= gidx;
            out_sum   <= sum_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Per-channel tap history; only the granted channel shifts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                for (int t = 0; t < 4; t++) begin
                    hist[c][t] <= '0;
                end
            end
        end else if (xfer) begin
            hist[gidx][0] <= sel_data;
            hist[gidx][1] <= hist[gidx][0];
            hist[gidx][2] <= hist[gidx][1];
            hist[gidx][3] <= hist[gidx][2];
        end
    end

endmodule

// File: tb/tb_fir4_chan_sched.sv
// tb/tb_fir4_chan_sched.sv - directed-vector bench for fir4_chan_sched, expectations follow FIR_SCHED_RR_EN
module tb_fir4_chan_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
    logic [5:0]  out_sum;

    int n_vec = 0;
    int n_err = 0;

    fir4_chan_sched #(.w(4), .NCH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_sum   (out_sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One cycle: drive, check grant before the edge, check result after it
    task automatic cyc(input string tag, input logic [3:0] v, input logic [15:0] d, input logic rdy,
                       input logic [3:0] er, input logic ev, input logic [5:0] es, input logic [1:0] ec);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        @(negedge clk);
        check({tag, ".rdy"}, 32'(in_ready), 32'(er));
        @(posedge clk);
        #1;
        check({tag, ".vld"}, 32'(out_valid), 32'(ev));
        check({tag, ".sum"}, 32'(out_sum), 32'(es));
        check({tag, ".ch"}, 32'(out_ch), 32'(ec));
    endtask

    task automatic do_reset(input string tag);
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        reset_n   = 1'b0;
        #1;
        check({tag, ".vld"}, 32'(out_valid), 32'd0);
        check({tag, ".sum"}, 32'(out_sum), 32'd0);
        check({tag, ".ch"}, 32'(out_ch), 32'd0);
        check({tag, ".rdy"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] er;
        logic [5:0] es;
        logic [1:0] ec;
        logic [3:0] v;
        logic [3:0] s1 [5];

        reset_n   = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        #2;
        do_reset("rst0");

        // Ch0 ramp, one result per cycle
        s1[0] = 4'd1; s1[1] = 4'd2; s1[2] = 4'd3; s1[3] = 4'd4; s1[4] = 4'd15;
        cyc("t1a", 4'b0001, {12'hFFF, s1[0]}, 1'b1, 4'b0001, 1'b1, 6'd1, 2'd0);
        cyc("t1b", 4'b0001, {12'hFFF, s1[1]}, 1'b1, 4'b0001, 1'b1, 6'd3, 2'd0);
        cyc("t1c", 4'b0001, {12'hFFF, s1[2]}, 1'b1, 4'b0001, 1'b1, 6'd6, 2'd0);
        cyc("t1d", 4'b0001, {12'hFFF, s1[3]}, 1'b1, 4'b0001, 1'b1, 6'd10, 2'd0);
        cyc("t1e", 4'b0001, {12'hFFF, s1[4]}, 1'b1, 4'b0001, 1'b1, 6'h18, 2'd0);

        // Ch0/ch1 all-ones streams interleaved
        do_reset("rst2");
        for (int i = 0; i < 8; i++) begin
            v  = (i % 2 == 0) ? 4'b0001 : 4'b0010;
            es = 6'(15 * (i / 2 + 1));
            ec = 2'(i % 2);
            cyc($sformatf("t2_%0d", i), v, 16'hAAFF, 1'b1, v, 1'b1, es, ec);
        end
        cyc("t2_ch0", 4'b0001, 16'hAAFF, 1'b1, 4'b0001, 1'b1, 6'h3C, 2'd0);

        // All channels valid continuously
        do_reset("rst3");
        for (int i = 0; i < 5; i++) begin
`ifdef FIR_SCHED_RR_EN
            er = 4'(1 << (i % 4));
            ec = 2'(i % 4);
            es = (i == 4) ? 6'd2 : 6'd1;
`else
            er = 4'b0001;
            ec = 2'd0;
            es = (i < 4) ? 6'(i + 1) : 6'd4;
`endif
            cyc($sformatf("t3_%0d", i), 4'b1111, 16'h1111, 1'b1, er, 1'b1, es, ec);
        end

        // Idle drops valid, keeps data and pointer
`ifdef FIR_SCHED_RR_EN
        cyc("t6_idle", 4'b0000, 16'h1111, 1'b1, 4'b0000, 1'b0, 6'd2, 2'd0);
        cyc("t6_next", 4'b1111, 16'h1111, 1'b1, 4'b0010, 1'b1, 6'd2, 2'd1);
`else
        cyc("t6_idle", 4'b0000, 16'h1111, 1'b1, 4'b0000, 1'b0, 6'd4, 2'd0);
        cyc("t6_next", 4'b1111, 16'h1111, 1'b1, 4'b0001, 1'b1, 6'd4, 2'd0);
`endif

        // Backpressure freeze and bubble-free release
        do_reset("rst4");
        cyc("t4a", 4'b0001, 16'h0001, 1'b1, 4'b0001, 1'b1, 6'd1, 2'd0);
        cyc("t4b", 4'b0001, 16'h0002, 1'b1, 4'b0001, 1'b1, 6'd3, 2'd0);
        cyc("t4c", 4'b0001, 16'h0003, 1'b1, 4'b0001, 1'b1, 6'd6, 2'd0);
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("t4_hold%0d", i), 4'b0001, 16'h0004, 1'b0, 4'b0000, 1'b1, 6'd6, 2'd0);
        end
        cyc("t4_rel", 4'b0001, 16'h0004, 1'b1, 4'b0001, 1'b1, 6'd10, 2'd0);

        // Mid-stream async reset clears result and history
        do_reset("rst5");
        cyc("t5a", 4'b0100, 16'hF6FF, 1'b1, 4'b0100, 1'b1, 6'd6, 2'd2);
        cyc("t5b", 4'b0100, 16'hF7FF, 1'b1, 4'b0100, 1'b1, 6'd13, 2'd2);
        cyc("t5c", 4'b0100, 16'hF8FF, 1'b1, 4'b0100, 1'b1, 6'd21, 2'd2);
        cyc("t5d", 4'b0100, 16'hF9FF, 1'b1, 4'b0100, 1'b1, 6'd30, 2'd2);
        #3;
        in_valid = '0;
        reset_n  = 1'b0;
        #1;
        check("t5_rst.vld", 32'(out_valid), 32'd0);
        check("t5_rst.sum", 32'(out_sum), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("t5_after", 4'b0100, 16'hF5FF, 1'b1, 4'b0100, 1'b1, 6'd5, 2'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
